cdc_fast2slow_tx: RTL and testbench
===================================

// Module: cdc_fast2slow_tx
// PURPOSE
//  - Fast-domain transmit end of a fast->slow 1-bit pulse crossing, the counterpart of cdc_slow2fast.
//  - Each single-cycle pluse_f is turned into one full 4-phase req/ack handshake toward the slow domain.
//  - Pulses that arrive while a handshake is in flight are counted and replayed, so none are lost until
//    the pending counter saturates.
//  - Single clock (clk_f). ack_s arrives asynchronously from the slow-domain receiver and is synchronized here.
// PARAMETERS
//  - SYNC_STAGES  default 2   flops in the ack_s synchronizer; legal values >= 2.
//  - PEND_W       default 4   width of the pending-pulse counter; maximum pending = 2**PEND_W-1.
//  - TIMEOUT_CYC  default 64  watchdog limit in clk_f cycles per handshake phase; used only with CDC_TX_TIMEOUT_EN.
// PORTS
//  - clk_f     in   1       fast clock; all logic is on its rising edge.
//  - rst_f     in   1       synchronous, active-high reset.
//  - pluse_f   in   1       single-cycle event to transfer; back-to-back cycles count as separate events.
//  - ack_s     in   1       acknowledge level from the slow-domain receiver; asynchronous to clk_f.
//  - req_s     out  1       request level to the slow domain; driven directly from a flop, no combinational logic.
//  - busy_f    out  1       1 while state != IDLE.
//  - pend_cnt  out  PEND_W  events accepted but not yet completed, including the one in flight.
//  - drop_f    out  1       1-cycle pulse when pluse_f is lost because pend_cnt is saturated.
//  - err_f     out  1       1-cycle pulse on handshake timeout; tied to 0 without CDC_TX_TIMEOUT_EN.
// BEHAVIOUR
//  - Reset (rst_f sampled 1): state=IDLE; req_s=0, busy_f=0, pend_cnt=0, drop_f=0, err_f=0; all synchronizer flops=0.
//    Reset mid-handshake abandons it: req_s falls on the next edge and the pending count is discarded.
//  - ack_sync is ack_s after SYNC_STAGES flops. The FSM uses only ack_sync, never raw ack_s.
//  - Pending counter, per edge: inc = pluse_f && pend_cnt != max; dec = handshake completion (see REQ_LO).
//    inc and dec in the same cycle leave the count unchanged.
//    pluse_f while pend_cnt == max: count unchanged and drop_f = 1 on the next cycle.
//  - FSM states:
//    IDLE:   if (pend_cnt != 0 || pluse_f) -> REQ_HI, req_s <= 1.
//            With pend_cnt == 0, pluse_f at edge n gives req_s = 1 after edge n (1-cycle latency).
//    REQ_HI: hold req_s = 1. On ack_sync == 1 -> REQ_LO, req_s <= 0.
//    REQ_LO: hold req_s = 0. On ack_sync == 0 -> IDLE and decrement pend_cnt.
//            Completion is this transition.
//  - Replay: IDLE re-launches on the edge after completion when pend_cnt != 0.
//    req_s is therefore low for at least 1 clk_f cycle between handshakes.
//  - ack_sync high while in IDLE (stale ack) is ignored.
//    A launch from IDLE still waits in REQ_HI for a 0 -> 1 transition of ack_sync, i.e. it does not enter
//    REQ_HI while ack_sync == 1. Implement as: IDLE launches only when ack_sync == 0.
//  - Throughput: each transfer takes at least 2*(SYNC_STAGES + receiver latency) cycles.
//    Sustained input faster than this fills the counter.
// CONFIGURATION
//  - Macro `CDC_TX_TIMEOUT_EN.
//  - Defined:
//    - Watchdog counter resets on every state change.
//    - If it reaches TIMEOUT_CYC in REQ_HI or REQ_LO: req_s <= 0, state -> IDLE, pend_cnt <= 0, err_f = 1 for 1 cycle.
//    - A pluse_f arriving in the same cycle as the timeout is counted: pend_cnt <= 1.
//  - Undefined: no watchdog logic; err_f is a constant 0; the FSM waits on ack indefinitely.
// TESTING
//  - Reset: hold rst_f high for 3 cycles with pluse_f=1 -> req_s=0, pend_cnt=0, busy_f=0 throughout,
//    and stay so for 1 cycle after release.
//  - Single pulse, bench model acks 3 cycles after req_s:
//    -> req_s rises 1 cycle after pluse_f; exactly one handshake; pend_cnt goes 1 -> 0; busy_f returns to 0.
//  - Burst: 5 back-to-back pluse_f during one handshake, slow responder
//    -> pend_cnt peaks at 5 (1 + 4 accepted in flight); exactly 5 req_s rising edges; drop_f never asserted.
//  - Saturation, PEND_W=2: 6 pulses with ack held low
//    -> pend_cnt sticks at 3; drop_f pulses 3 times; exactly 3 handshakes complete after ack resumes.
//  - Simultaneous event: pluse_f on the completion cycle with pend_cnt=1
//    -> pend_cnt stays 1; a new handshake launches the next cycle.
//  - Timeout, macro defined, TIMEOUT_CYC=8, ack never rises
//    -> err_f pulses 8 cycles after entering REQ_HI; req_s=0; state IDLE; pend_cnt=0.
//    Without the macro: req_s stays high and err_f stays 0.

Source files
------------

// File: rtl/cdc_fast2slow_tx.sv
// Fast-domain transmit end of a fast->slow single-bit pulse crossing.
// Each pluse_f becomes one full 4-phase req_s/ack_s handshake. Pulses that arrive while a
// handshake is in flight are counted in pend_cnt and replayed, until the counter saturates.
// Optional handshake watchdog: define CDC_TX_TIMEOUT_EN.
module cdc_fast2slow_tx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PEND_W      = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk_f,
  input  logic              rst_f,
  input  logic              pluse_f,
  input  logic              ack_s,
  output logic              req_s,
  output logic              busy_f,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              drop_f,
  output logic              err_f
);

  typedef enum logic [1:0] {StIdle, StReqHi, StReqLo} state_e;

  localparam logic [PEND_W-1:0] PendMax = '1;

  // Elaboration-time parameter sanity.
  if (SYNC_STAGES < 2 || PEND_W < 1 || TIMEOUT_CYC < 1) begin : gen_bad_param
    $error("cdc_fast2slow_tx: illegal parameter value");
  end

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [PEND_W-1:0]       pend_q, pend_d;
  logic                    drop_q, drop_d;
  logic [SYNC_STAGES-1:0]  ack_sync_q;
  logic                    ack_sync;
  logic                    complete;
  logic                    inc;
  logic                    timeout;

  // ack_s synchronizer; only the last stage is ever used by the FSM.
  always_ff @(posedge clk_f) begin
    if (rst_f) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_s};
    end
  end

  assign ack_sync = ack_sync_q[SYNC_STAGES-1];

`ifdef CDC_TX_TIMEOUT_EN
  localparam int unsigned    WdW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  logic [WdW-1:0] wdog_q, wdog_d;
  logic           err_q;

  // Fires on the edge where the per-phase cycle count would reach TIMEOUT_CYC.
  assign timeout = (state_q != StIdle) && (wdog_q == WdLast);

  // Watchdog restarts on every state change and only runs while a handshake is open.
  always_comb begin
    wdog_d = '0;
    if (state_d == state_q && state_q != StIdle) begin
      wdog_d = wdog_q + WdW'(1);
    end
  end

  // Watchdog and error pulse registers.
  always_ff @(posedge clk_f) begin
    if (rst_f) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= timeout;
    end
  end

  assign err_f = err_q;
`else
  assign timeout = 1'b0;
  assign err_f   = 1'b0;
`endif

  assign complete = (state_q == StReqLo) && !ack_sync;
  assign inc      = pluse_f && (pend_q != PendMax);

  // Handshake FSM, pending counter and drop detection.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pend_d  = pend_q;
    drop_d  = pluse_f && (pend_q == PendMax);

    unique case (state_q)
      StIdle: begin
        // A stale ack left high blocks the launch until the receiver drops it.
        if ((pend_q != '0 || pluse_f) && !ack_sync) begin
          state_d = StReqHi;
          req_d   = 1'b1;
        end
      end
      StReqHi: begin
        req_d = 1'b1;
        if (ack_sync) begin
          state_d = StReqLo;
          req_d   = 1'b0;
        end
      end
      StReqLo: begin
        req_d = 1'b0;
        if (!ack_sync) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        req_d   = 1'b0;
      end
    endcase

    unique case ({inc, complete})
      2'b10:   pend_d = pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase

    // Timeout abandons the handshake and the backlog; a same-cycle pulse still counts.
    if (timeout) begin
      state_d = StIdle;
      req_d   = 1'b0;
      pend_d  = pluse_f ? PEND_W'(1) : '0;
      drop_d  = 1'b0;
    end
  end

  // State, request, pending and drop registers.
  always_ff @(posedge clk_f) begin
    if (rst_f) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      pend_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign req_s    = req_q;
  assign busy_f   = (state_q != StIdle);
  assign pend_cnt = pend_q;
  assign drop_f   = drop_q;

endmodule

// File: tb/tb_cdc_fast2slow_tx.sv
// Directed bench for cdc_fast2slow_tx. Three instances: default parameters, PEND_W=2 for
// saturation, TIMEOUT_CYC=8 for the watchdog. Inputs change and outputs are sampled 2 time
// units after the rising edge; the ack responders and monitors run 1 unit after the edge.
module tb_cdc_fast2slow_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       pl0 = 1'b0, ack0 = 1'b0, req0, busy0, drop0, err0;
  logic [3:0] pend0;
  logic       pl1 = 1'b0, ack1 = 1'b0, req1, busy1, drop1, err1;
  logic [1:0] pend1;
  logic       pl2 = 1'b0, ack2 = 1'b0, req2, busy2, drop2, err2;
  logic [3:0] pend2;

  int total = 0;
  int bad   = 0;

  // Receiver models: auto mode echoes req after dly cycles, manual mode drives man*.
  bit en0 = 1'b0, man0 = 1'b0, en1 = 1'b0, man1 = 1'b0;
  int dly0 = 3, dly1 = 2, cnt0 = 0, cnt1 = 0;
  // Monitors: req rising edges, busy falling edges (completions), drop pulses.
  int rises0 = 0, done0 = 0, drops0 = 0, rises1 = 0, done1 = 0, drops1 = 0;
  logic req0_p = 1'b0, busy0_p = 1'b0, req1_p = 1'b0, busy1_p = 1'b0;

  cdc_fast2slow_tx u_dut0 (
    .clk_f(clk), .rst_f(rst), .pluse_f(pl0), .ack_s(ack0), .req_s(req0),
    .busy_f(busy0), .pend_cnt(pend0), .drop_f(drop0), .err_f(err0)
  );

  cdc_fast2slow_tx #(.PEND_W(2)) u_dut1 (
    .clk_f(clk), .rst_f(rst), .pluse_f(pl1), .ack_s(ack1), .req_s(req1),
    .busy_f(busy1), .pend_cnt(pend1), .drop_f(drop1), .err_f(err1)
  );

  cdc_fast2slow_tx #(.TIMEOUT_CYC(8)) u_dut2 (
    .clk_f(clk), .rst_f(rst), .pluse_f(pl2), .ack_s(ack2), .req_s(req2),
    .busy_f(busy2), .pend_cnt(pend2), .drop_f(drop2), .err_f(err2)
  );

  // Receiver models and event monitors.
  always @(posedge clk) begin
    #1;
    if (en0) begin
      if (ack0 != req0) begin
        cnt0++;
        if (cnt0 >= dly0) begin ack0 = req0; cnt0 = 0; end
      end else cnt0 = 0;
    end else begin
      cnt0 = 0;
      ack0 = man0;
    end
    if (en1) begin
      if (ack1 != req1) begin
        cnt1++;
        if (cnt1 >= dly1) begin ack1 = req1; cnt1 = 0; end
      end else cnt1 = 0;
    end else begin
      cnt1 = 0;
      ack1 = man1;
    end
    if (req0 === 1'b1 && req0_p === 1'b0) rises0++;
    if (busy0 === 1'b0 && busy0_p === 1'b1) done0++;
    if (drop0 === 1'b1) drops0++;
    if (req1 === 1'b1 && req1_p === 1'b0) rises1++;
    if (busy1 === 1'b0 && busy1_p === 1'b1) done1++;
    if (drop1 === 1'b1) drops1++;
    req0_p = req0; busy0_p = busy0; req1_p = req1; busy1_p = busy1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; pl0 = 1'b1; pl1 = 1'b1; pl2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (req0 !== 1'b0) begin bad++; $display("FAIL reset_req[%0d]: got %b want 0", i, req0); end
      total++; if (pend0 !== 4'd0) begin bad++; $display("FAIL reset_pend[%0d]: got %0d want 0", i, pend0); end
      total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy0); end
    end
    rst = 1'b0; pl0 = 1'b0; pl1 = 1'b0; pl2 = 1'b0;
    tick();
    total++; if (req0 !== 1'b0) begin bad++; $display("FAIL post_reset_req: got %b want 0", req0); end
    total++; if (pend0 !== 4'd0) begin bad++; $display("FAIL post_reset_pend: got %0d want 0", pend0); end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b want 0", busy0); end
    total++; if (drop0 !== 1'b0) begin bad++; $display("FAIL post_reset_drop: got %b want 0", drop0); end
    total++; if (err0 !== 1'b0) begin bad++; $display("FAIL post_reset_err: got %b want 0", err0); end
  endtask

  task automatic test_single_pulse();
    int r0, d0, n;
    logic [3:0] pmax;
    en0 = 1'b1; dly0 = 3;
    r0 = rises0; d0 = done0;
    pl0 = 1'b1;
    tick();
    pl0 = 1'b0;
    total++; if (req0 !== 1'b1) begin bad++; $display("FAIL single_req_latency: got %b want 1", req0); end
    total++; if (pend0 !== 4'd1) begin bad++; $display("FAIL single_pend_1: got %0d want 1", pend0); end
    pmax = pend0;
    n = 0;
    while (busy0 !== 1'b0 && n < 60) begin
      tick(); n++;
      if (pend0 > pmax) pmax = pend0;
    end
    total++; if (busy0 !== 1'b0) begin bad++; $display("FAIL single_timeout: busy got %b want 0", busy0); end
    total++; if (rises0 - r0 != 1) begin bad++; $display("FAIL single_rises: got %0d want 1", rises0 - r0); end
    total++; if (done0 - d0 != 1) begin bad++; $display("FAIL single_done: got %0d want 1", done0 - d0); end
    total++; if (pend0 !== 4'd0) begin bad++; $display("FAIL single_pend_0: got %0d want 0", pend0); end
    total++; if (pmax !== 4'd1) begin bad++; $display("FAIL single_pend_max: got %0d want 1", pmax); end
  endtask

  task automatic test_back_to_back();
    int r0, d0, x0, n;
    logic [3:0] pmax;
    en0 = 1'b1; dly0 = 6;
    r0 = rises0; d0 = done0; x0 = drops0;
    for (int i = 0; i < 5; i++) begin
      pl0 = 1'b1;
      tick();
    end
    pl0 = 1'b0;
    total++; if (pend0 !== 4'd5) begin bad++; $display("FAIL burst_pend_peak: got %0d want 5", pend0); end
    pmax = pend0;
    n = 0;
    while (!(busy0 === 1'b0 && pend0 === 4'd0) && n < 400) begin
      tick(); n++;
      if (pend0 > pmax) pmax = pend0;
    end
    total++; if (busy0 !== 1'b0 || pend0 !== 4'd0) begin
      bad++; $display("FAIL burst_drain: busy=%b pend=%0d want 0 0", busy0, pend0);
    end
    total++; if (rises0 - r0 != 5) begin bad++; $display("FAIL burst_rises: got %0d want 5", rises0 - r0); end
    total++; if (done0 - d0 != 5) begin bad++; $display("FAIL burst_done: got %0d want 5", done0 - d0); end
    total++; if (drops0 != x0) begin bad++; $display("FAIL burst_drops: got %0d want 0", drops0 - x0); end
    total++; if (pmax !== 4'd5) begin bad++; $display("FAIL burst_pend_max: got %0d want 5", pmax); end
  endtask

  task automatic test_simultaneous();
    int n;
    en0 = 1'b0; man0 = 1'b0;
    pl0 = 1'b1;
    tick();
    pl0 = 1'b0;
    man0 = 1'b1;
    n = 0;
    while (req0 !== 1'b0 && n < 20) begin tick(); n++; end
    total++; if (req0 !== 1'b0 || busy0 !== 1'b1) begin
      bad++; $display("FAIL simul_reqlo: req=%b busy=%b want 0 1", req0, busy0);
    end
    man0 = 1'b0;
    tick(); tick(); tick();
    total++; if (busy0 !== 1'b1 || pend0 !== 4'd1) begin
      bad++; $display("FAIL simul_pre: busy=%b pend=%0d want 1 1", busy0, pend0);
    end
    pl0 = 1'b1;
    tick();
    pl0 = 1'b0;
    total++; if (pend0 !== 4'd1) begin bad++; $display("FAIL simul_pend: got %0d want 1", pend0); end
    total++; if (busy0 !== 1'b0 || req0 !== 1'b0) begin
      bad++; $display("FAIL simul_idle: busy=%b req=%b want 0 0", busy0, req0);
    end
    tick();
    total++; if (req0 !== 1'b1 || busy0 !== 1'b1) begin
      bad++; $display("FAIL simul_relaunch: req=%b busy=%b want 1 1", req0, busy0);
    end
    en0 = 1'b1; dly0 = 3;
    n = 0;
    while (!(busy0 === 1'b0 && pend0 === 4'd0) && n < 60) begin tick(); n++; end
    total++; if (pend0 !== 4'd0 || busy0 !== 1'b0) begin
      bad++; $display("FAIL simul_drain: pend=%0d busy=%b want 0 0", pend0, busy0);
    end
  endtask

  task automatic test_saturation();
    int r1, d1, x1, n;
    en1 = 1'b0; man1 = 1'b0;
    r1 = rises1; d1 = done1; x1 = drops1;
    for (int i = 0; i < 6; i++) begin
      pl1 = 1'b1;
      tick();
    end
    pl1 = 1'b0;
    total++; if (pend1 !== 2'd3) begin bad++; $display("FAIL sat_pend: got %0d want 3", pend1); end
    total++; if (drops1 - x1 != 3) begin bad++; $display("FAIL sat_drops: got %0d want 3", drops1 - x1); end
    tick();
    total++; if (drop1 !== 1'b0) begin bad++; $display("FAIL sat_drop_width: got %b want 0", drop1); end
    total++; if (pend1 !== 2'd3) begin bad++; $display("FAIL sat_pend_hold: got %0d want 3", pend1); end
    en1 = 1'b1; dly1 = 2;
    n = 0;
    while (!(busy1 === 1'b0 && pend1 === 2'd0) && n < 200) begin tick(); n++; end
    total++; if (pend1 !== 2'd0 || busy1 !== 1'b0) begin
      bad++; $display("FAIL sat_drain: pend=%0d busy=%b want 0 0", pend1, busy1);
    end
    total++; if (done1 - d1 != 3) begin bad++; $display("FAIL sat_done: got %0d want 3", done1 - d1); end
    total++; if (rises1 - r1 != 3) begin bad++; $display("FAIL sat_rises: got %0d want 3", rises1 - r1); end
    total++; if (drops1 - x1 != 3) begin bad++; $display("FAIL sat_drops_final: got %0d want 3", drops1 - x1); end
  endtask

  task automatic test_timeout();
    ack2 = 1'b0;
    pl2 = 1'b1;
    tick();
    pl2 = 1'b0;
    total++; if (req2 !== 1'b1) begin bad++; $display("FAIL to_req_rise: got %b want 1", req2); end
    for (int i = 1; i < 8; i++) begin
      tick();
      total++; if (err2 !== 1'b0 || req2 !== 1'b1) begin
        bad++; $display("FAIL to_early[%0d]: err=%b req=%b want 0 1", i, err2, req2);
      end
    end
    tick();
`ifdef CDC_TX_TIMEOUT_EN
    total++; if (err2 !== 1'b1) begin bad++; $display("FAIL to_err: got %b want 1", err2); end
    total++; if (req2 !== 1'b0) begin bad++; $display("FAIL to_req: got %b want 0", req2); end
    total++; if (busy2 !== 1'b0 || pend2 !== 4'd0) begin
      bad++; $display("FAIL to_idle: busy=%b pend=%0d want 0 0", busy2, pend2);
    end
    tick();
    total++; if (err2 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL to_err_width: err=%b busy=%b want 0 0", err2, busy2);
    end
`else
    total++; if (err2 !== 1'b0) begin bad++; $display("FAIL to_err_off: got %b want 0", err2); end
    total++; if (req2 !== 1'b1) begin bad++; $display("FAIL to_req_held: got %b want 1", req2); end
    total++; if (busy2 !== 1'b1 || pend2 !== 4'd1) begin
      bad++; $display("FAIL to_wait: busy=%b pend=%0d want 1 1", busy2, pend2);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_simultaneous();
    test_saturation();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
